// File: rtl/cac_fns_pkg.sv
// Shared constants, state type and FNS/FTF helper functions for the
// Fibonacci-numeral-system CAC coder/decoder pair.
package cac_fns_pkg;

   localparam int unsigned FNS_WIRES = 9;
   localparam int unsigned FNS_BLEN  = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Fibonacci weight of wire k: w[0]=w[1]=1, w[k]=w[k-1]+w[k-2]
   function automatic logic [FNS_BLEN-1:0] fns_weight(input int unsigned k);
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] t;
      a = 32'd1;
      b = 32'd1;
      for (int unsigned i = 2; i < 32; i++) begin
         if (i <= k) begin
            t = a + b;
            a = b;
            b = t;
         end
      end
      return FNS_BLEN'(b);
   endfunction

   // An odd wire set to 1 needs both even neighbours set to 1
   function automatic logic ftf_violation(input logic [31:0] word,
                                          input int unsigned wires);
      logic v;
      v = 1'b0;
      for (int unsigned m = 1; m < 16; m++) begin
         if (m <= (wires - 1) / 2) begin
            if (!word[5'(2*m)] && word[5'(2*m-1)])
               v = 1'b1;
            if (word[5'(2*m-1)] && !word[5'(2*m-2)])
               v = 1'b1;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/cac_ftf_check.sv
// Combinational forbidden-transition-free check of one codeword; shared
// between the coder and decoder sides.
module cac_ftf_check
   import cac_fns_pkg::*;
#(
   parameter int unsigned WIRES = FNS_WIRES
) (
   input  logic [WIRES-1:0] i_word,
   output logic             o_violation_c
);

   assign o_violation_c = ftf_violation(32'(i_word), WIRES);

endmodule

// File: rtl/cac_fns_seq_decoder.sv
// Handshaked bit-serial FNS decoder: accumulates Fibonacci weights MSB wire
// first and keeps a saturating count of FTF-violating codewords.
module cac_fns_seq_decoder
   import cac_fns_pkg::*;
#(
   parameter int unsigned WIRES = FNS_WIRES,
   parameter int unsigned BLEN  = FNS_BLEN,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIRES-1:0] tsv_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [BLEN-1:0]  data_out,
   output logic             ftf_err,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             err_clear,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned KW = (WIRES > 1) ? $clog2(WIRES) : 1;

   state_e           r_state,  w_state_nxt;
   logic [WIRES-1:0] r_word,   w_word_nxt;
   logic [BLEN-1:0]  r_acc,    w_acc_nxt;
   logic [KW-1:0]    r_k,      w_k_nxt;
   logic             r_flag,   w_flag_nxt;
   logic [BLEN-1:0]  r_data,   w_data_nxt;
   logic             r_err,    w_err_nxt;
   logic             r_ovalid, w_ovalid_nxt;
   logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;

   logic             w_ftf;
   logic             w_accept;
   logic             w_bit;
   logic [BLEN-1:0]  w_sum;

   cac_ftf_check #(
      .WIRES (WIRES)
   ) u_ftf (
      .i_word        (tsv_in),
      .o_violation_c (w_ftf)
   );

   // In DONE the sink's ready is forwarded so retire and accept share an edge
   assign in_ready = !reset && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
   assign w_accept = in_valid && in_ready;

   assign w_bit = r_word[r_k];
   assign w_sum = r_acc + (w_bit ? BLEN'(fns_weight(32'(r_k))) : '0);

   // Next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_word_nxt   = r_word;
      w_acc_nxt    = r_acc;
      w_k_nxt      = r_k;
      w_flag_nxt   = r_flag;
      w_data_nxt   = r_data;
      w_err_nxt    = r_err;
      w_ovalid_nxt = r_ovalid;
      w_cnt_nxt    = r_cnt;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = DECODE;
               w_word_nxt  = tsv_in;
               w_flag_nxt  = w_ftf;
               w_acc_nxt   = '0;
               w_k_nxt     = KW'(WIRES - 1);
            end
         end
         DECODE: begin
            w_acc_nxt = w_sum;
            w_k_nxt   = r_k - KW'(1);
            if (r_k == '0) begin
               w_state_nxt  = DONE;
               w_data_nxt   = w_sum;
               w_err_nxt    = r_flag;
               w_ovalid_nxt = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_ovalid_nxt = 1'b0;
               if (in_valid) begin
                  w_state_nxt = DECODE;
                  w_word_nxt  = tsv_in;
                  w_flag_nxt  = w_ftf;
                  w_acc_nxt   = '0;
                  w_k_nxt     = KW'(WIRES - 1);
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Clear wins over a same-edge increment
      if (err_clear)
         w_cnt_nxt = '0;
      else if (w_accept && w_ftf && !(&r_cnt))
         w_cnt_nxt = r_cnt + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_word   <= '0;
         r_acc    <= '0;
         r_k      <= '0;
         r_flag   <= 1'b0;
         r_data   <= '0;
         r_err    <= 1'b0;
         r_ovalid <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_word   <= w_word_nxt;
         r_acc    <= w_acc_nxt;
         r_k      <= w_k_nxt;
         r_flag   <= w_flag_nxt;
         r_data   <= w_data_nxt;
         r_err    <= w_err_nxt;
         r_ovalid <= w_ovalid_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign data_out  = r_data;
   assign ftf_err   = r_err;
   assign out_valid = r_ovalid;
   assign err_count = r_cnt;

endmodule
